// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU share arbiter: op codes, FSM encoding, default widths.
// Optional condition-code outputs are enabled with the ALU_SHARE_CC_EN macro.
package alu_share_pkg;

    localparam int unsigned WIDTH_DEF = 64;
    localparam int unsigned NREQ_DEF  = 2;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin grant; the last-grant pointer lives in the parent.
module rr_arbiter2 (
    input  logic [1:0] i_req_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // One-hot grant: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        o_grant = 2'b00;
        case (i_req_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters, one op in flight.
// Accept in IDLE, drive the ALU for one EXEC cycle, hold the tagged result in RESP.
// Define ALU_SHARE_CC_EN to add condition-code outputs tracking requester 0 ops.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREQ  = NREQ_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][1:0]        req_ctrl,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
    output logic [1:0]                  alu_control,
    output logic [WIDTH-1:0]            alu_a,
    output logic [WIDTH-1:0]            alu_b,
    input  logic [WIDTH-1:0]            alu_ans,
    input  logic                        alu_overflow,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_id,
    output logic [WIDTH-1:0]            rsp_ans,
    output logic                        rsp_overflow,
    output logic                        busy
`ifdef ALU_SHARE_CC_EN
    ,
    output logic                        cc_zf,
    output logic                        cc_sf,
    output logic                        cc_of
`endif
);

    state_t          r_state;
    logic            r_last_grant;
    logic            r_op_id;
    logic [NREQ-1:0] w_grant;
    logic            w_fire;
    logic            w_id;

    rr_arbiter2 u_rr (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Ready only in IDLE, only to the granted requester that is actually valid.
    assign req_ready = (r_state == IDLE) ? (w_grant & req_valid) : '0;
    assign w_fire    = |req_ready;
    assign w_id      = req_ready[1];
    assign busy      = (r_state != IDLE);

    // Main FSM: operand capture on accept, result capture after EXEC, hold until drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_op_id      <= 1'b0;
            alu_control  <= 2'b00;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_ans      <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        alu_control  <= req_ctrl[w_id];
                        alu_a        <= req_a[w_id];
                        alu_b        <= req_b[w_id];
                        r_op_id      <= w_id;
                        r_last_grant <= w_id;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_ans      <= alu_ans;
                    rsp_overflow <= alu_overflow;
                    rsp_id       <= r_op_id;
                    rsp_valid    <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_CC_EN
    // Condition codes follow requester 0 results only; requester 1 leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_zf <= 1'b0;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if ((r_state == EXEC) && !r_op_id) begin
            cc_zf <= (alu_ans == '0);
            cc_sf <= alu_ans[WIDTH-1];
            cc_of <= alu_overflow;
        end
    end
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 64-bit ALU (ctrl 00=add, 01=sub, 10=and, 11=xor; outputs result and overflow) between two requesters.
- Requester 0 is the execute stage; requester 1 is the address/aux computation path.
- Arbitrates round-robin, registers operands, drives the external ALU for one cycle, captures result and overflow, and returns them with a tagged response handshake.
- One operation in flight at a time.

Parameters:
- WIDTH, 64, operand/result width.
- NREQ, 2, number of requesters (fixed at 2 in this revision).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; at most one bit set.
- req_ctrl  in  2x2  per-requester ALU op.
- req_a  in  2xWIDTH  per-requester operand a, signed.
- req_b  in  2xWIDTH  per-requester operand b, signed.
- alu_control  out  2  to shared ALU.
- alu_a  out  WIDTH  to shared ALU.
- alu_b  out  WIDTH  to shared ALU.
- alu_ans  in  WIDTH  from shared ALU.
- alu_overflow  in  1  from shared ALU.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_ans  out  WIDTH  captured result.
- rsp_overflow  out  1  captured overflow.
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all response outputs 0; rsp_id=0.
  - alu_control/alu_a/alu_b=0; last_grant=1, so requester 0 wins the first contention.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready asserted combinationally to the granted requester only, and only if its req_valid=1.
  - Handshake fires on valid&ready.
  - Grant rule: if only one valid, grant it. If both valid, grant ~last_grant.
  - On fire: latch ctrl/a/b/id into operand regs, set last_grant=id, go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_control/alu_a/alu_b driven from the operand regs. These are held stable from the cycle after accept until the next accept.
  - At the clock edge, capture alu_ans/alu_overflow into rsp_ans/rsp_overflow, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid held with rsp_id/ans/overflow stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - No new accept is allowed in the same cycle as the response handshake.
- Latency: accept at edge t; rsp_valid visible after edge t+1 (2 cycles from request to response). Minimum issue interval is 3 cycles.
- req_ready=0 in EXEC and RESP; requesters must hold valid and payload until accepted.
- A requester that drops valid before grant is simply not served; no state is kept.
- Arithmetic: none internal. Result and overflow come from the ALU unmodified; a and b are passed as two's-complement WIDTH bits.
- rsp_ready is ignored outside RESP.
- Reset asserted in EXEC/RESP aborts the operation; no response is issued for it.

Optional Feature:
- Macro: ALU_SHARE_CC_EN.
- With the macro defined:
  - Extra outputs cc_zf, cc_sf, cc_of (1 bit each, reset 0).
  - Updated at the EXEC capture edge only when the operation belongs to requester 0: zf = (alu_ans==0), sf = alu_ans[WIDTH-1], of = alu_overflow.
  - Requester 1 operations leave the CC unchanged.
- Without the macro: ports absent, no CC logic.

Decomposition:
- Package alu_share_pkg holds:
  - Op constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11.
  - State encoding IDLE/EXEC/RESP.
  - WIDTH default.
- One sub-module: rr_arbiter2, a combinational 2-way round-robin grant from req_valid and last_grant. Pointer storage stays in the parent.

Test Plan:
- Req0 add, a=11, b=4, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_ans=15, rsp_overflow=0; alu_control=00 during EXEC.
- Req1 sub, a=-11, b=4 -> rsp_id=1, rsp_ans=-15, overflow=0; with CC enabled, cc_* unchanged from prior values.
- Both valid continuously, four ops each -> grants strictly alternate 0,1,0,1,…, starting with 0 after reset; never two req_ready bits high.
- Req0 add, a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> rsp_ans=64'h8000_0000_0000_0000, rsp_overflow=1; with CC enabled, cc_sf=1, cc_of=1, cc_zf=0.
- Backpressure: rsp_ready low 5 cycles -> rsp_* stable, req_ready=0 throughout, new request on req1 accepted only the cycle after the response handshake.
- rst pulsed during EXEC of req0 xor, a=5, b=5 -> all outputs zero immediately, no rsp_valid for that op; the next contending pair grants req0 first.
